forth_sequencer: RTL

Instruction sequencer feeding the stack CPU's control unit. Holds a small loadable program memory of Forth-style instructions, fetches and decodes one instruction per two clocks, and drives the 4-bit `command` and 16-bit literal `data` into the control-unit/stack pair. A shadow depth counter mirrors the stack pointer, so underflow, overflow and illegal opcodes are caught before they reach the stack.

---
 rtl/forth_pkg.sv | 38 +++
 rtl/forth_sequencer_prog_mem.sv | 27 ++
 rtl/forth_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/forth_pkg.sv
// Shared opcodes, FSM states, error codes and instruction field widths
// for the Forth-style instruction sequencer.
package forth_pkg;

  localparam int OPC_W   = 4;
  localparam int LIT_W   = 16;
  localparam int INSTR_W = OPC_W + LIT_W;
  localparam int DEPTH_W = 7;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_PUSH = 4'd1;
  localparam logic [OPC_W-1:0] OP_POP  = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd3;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'd4;
  localparam logic [OPC_W-1:0] OP_DUP  = 4'd5;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERROR = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_UNDER   = 2'd1,
    ERR_OVER    = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_code_t;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] instr_opc(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1:LIT_W];
  endfunction

endpackage

// File: rtl/forth_sequencer_prog_mem.sv
// Program memory: one write port, one registered read port (1-cycle latency).
// The array is not reset so a program survives a sequencer reset.
module prog_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/forth_sequencer.sv
// Instruction sequencer: fetches one instruction every two clocks from the
// program memory, checks it against a shadow stack depth and issues
// command/literal pulses to the control unit.
module forth_sequencer
  import forth_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int AW         = $clog2(PROG_DEPTH),
  parameter int STACK_MAX  = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [INSTR_W-1:0]   load_data,
  input  logic                 start,
  output logic [OPC_W-1:0]     command,
  output logic [LIT_W-1:0]     data,
  output logic                 cmd_valid,
  output logic [AW-1:0]        pc,
  output logic [DEPTH_W-1:0]   depth,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam logic [DEPTH_W-1:0] DMAX    = DEPTH_W'(STACK_MAX);
  localparam logic [AW-1:0]      PC_LAST = AW'(PROG_DEPTH - 1);

  seq_state_t         state_q;
  logic [OPC_W-1:0]   cmd_q;
  logic [LIT_W-1:0]   data_q;
  logic               vld_q;
  logic [AW-1:0]      pc_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  err_code_t          code_q;

  logic [INSTR_W-1:0] instr;
  logic [OPC_W-1:0]   opc;
  logic [LIT_W-1:0]   lit;

  // Loads are locked out while a program runs so the fetch stream is stable.
  prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW),
    .DW    (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (load_en & ~busy_q),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  assign opc = instr_opc(instr);
  assign lit = instr[LIT_W-1:0];

  err_code_t          exc_d;
  logic [DEPTH_W-1:0] depth_d;

  // Decode the fetched word: legality against the shadow depth and next depth.
  always_comb begin
    exc_d   = ERR_NONE;
    depth_d = depth_q;
    case (opc)
      OP_NOP, OP_HALT: ;
      OP_PUSH: begin
        if (depth_q == DMAX) exc_d = ERR_OVER;
        else                 depth_d = depth_q + 7'd1;
      end
      OP_POP: begin
        if (depth_q == '0) exc_d = ERR_UNDER;
        else               depth_d = depth_q - 7'd1;
      end
      OP_ADD, OP_MUL: begin
        if (depth_q < 7'd2) exc_d = ERR_UNDER;
        else                depth_d = depth_q - 7'd1;
      end
      OP_DUP: begin
        if (depth_q == '0)        exc_d = ERR_UNDER;
        else if (depth_q == DMAX) exc_d = ERR_OVER;
        else                      depth_d = depth_q + 7'd1;
      end
      default: exc_d = ERR_ILLEGAL;
    endcase
  end

  // Sequencer FSM with all outputs registered; command pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      depth_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      cmd_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          if (exc_d != ERR_NONE) begin
            // Abort: pc and depth stay at the faulting point.
            err_q   <= 1'b1;
            code_q  <= exc_d;
            busy_q  <= 1'b0;
            state_q <= S_ERROR;
          end else if (opc == OP_HALT) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_HALT;
          end else begin
            if (opc != OP_NOP) begin
              cmd_q  <= opc;
              data_q <= (opc == OP_PUSH) ? lit : '0;
              vld_q  <= 1'b1;
            end
            depth_q <= depth_d;
            if (pc_q == PC_LAST) begin
              // End of memory: finish instead of wrapping to address 0.
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_HALT;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign command   = cmd_q;
  assign data      = data_q;
  assign cmd_valid = vld_q;
  assign pc        = pc_q;
  assign depth     = depth_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
